// File: rtl/branch_fifo_pkg.sv
// Shared redirect types and default sizes for execute, branch_fifo and the pc stage.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef THREAD_WIDTH
`define THREAD_WIDTH 3
`endif

package branch_fifo_pkg;
    localparam int XLEN              = `XLEN;
    localparam int THREAD_WIDTH      = `THREAD_WIDTH;
    localparam int BRANCH_FIFO_DEPTH = 8;

    typedef struct packed {
        logic [XLEN-1:0]         pc;
        logic [THREAD_WIDTH-1:0] thread_id;
    } branch_req_t;
endpackage

// File: rtl/branch_fifo_mem.sv
// Register-array storage for branch_fifo: one append write port, one async read port.
// With BRANCH_FIFO_DEDUP_EN defined, a second write port rewrites a pending entry in place.
module branch_fifo_mem
    import branch_fifo_pkg::*;
#(
    parameter int DEPTH = BRANCH_FIFO_DEPTH,
    parameter int WIDTH = XLEN + THREAD_WIDTH,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
`ifdef BRANCH_FIFO_DEDUP_EN
    input  logic             i_we2,
    input  logic [AW-1:0]    i_waddr2,
    input  logic [WIDTH-1:0] i_wdata2,
`endif
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Storage is cleared on reset so the head outputs read zero while empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (i_we) r_mem[i_waddr] <= i_wdata;
`ifdef BRANCH_FIFO_DEDUP_EN
            if (i_we2) r_mem[i_waddr2] <= i_wdata2;
`endif
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/branch_fifo.sv
// FWFT queue of branch redirects from execute to the pc stage; control lives here.
// Define BRANCH_FIFO_DEDUP_EN to coalesce redirects per thread (newest pc wins).
module branch_fifo
    import branch_fifo_pkg::*;
#(
    parameter int XLEN         = branch_fifo_pkg::XLEN,
    parameter int THREAD_WIDTH = branch_fifo_pkg::THREAD_WIDTH,
    parameter int DEPTH        = BRANCH_FIFO_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [XLEN-1:0]            push_pc_i,
    input  logic [THREAD_WIDTH-1:0]    push_thread_id_i,
    input  logic                       br_ack_i,
    output logic [XLEN-1:0]            br_pc_o,
    output logic [THREAD_WIDTH-1:0]    br_thread_id_o,
    output logic                       branch_fifo_empty_o,
    output logic                       full_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       overflow_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int DW = XLEN + THREAD_WIDTH;

    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;

    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_hit;
    logic          w_push;
    logic          w_drop;
    logic [DW-1:0] w_wdata;
    logic [DW-1:0] w_rdata;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_pop   = br_ack_i && !w_empty;
    assign w_wdata = {push_pc_i, push_thread_id_i};

`ifdef BRANCH_FIFO_DEDUP_EN
    localparam int NT = 1 << THREAD_WIDTH;

    logic [NT-1:0] r_pend;
    logic [PW-1:0] r_slot [NT];

    // A pending entry leaving as head this cycle can't be rewritten; append instead.
    assign w_hit = push_i && r_pend[push_thread_id_i]
                   && !(w_pop && (r_slot[push_thread_id_i] == r_rd_ptr));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend <= '0;
            for (int i = 0; i < NT; i++) r_slot[i] <= '0;
        end else begin
            if (w_pop) r_pend[w_rdata[THREAD_WIDTH-1:0]] <= 1'b0;
            if (w_push) begin
                r_pend[push_thread_id_i] <= 1'b1;
                r_slot[push_thread_id_i] <= r_wr_ptr;
            end
        end
    end
`else
    assign w_hit = 1'b0;
`endif

    assign w_push = push_i && !w_hit && (!w_full || w_pop);
    assign w_drop = push_i && !w_hit && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop) r_overflow <= 1'b1;
        end
    end

    branch_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (DW)
    ) u_mem (
        .clk      (clk),
        .rst      (rst),
        .i_we     (w_push),
        .i_waddr  (r_wr_ptr),
        .i_wdata  (w_wdata),
`ifdef BRANCH_FIFO_DEDUP_EN
        .i_we2    (w_hit),
        .i_waddr2 (r_slot[push_thread_id_i]),
        .i_wdata2 (w_wdata),
`endif
        .i_raddr  (r_rd_ptr),
        .o_rdata  (w_rdata)
    );

    assign br_pc_o             = w_rdata[DW-1:THREAD_WIDTH];
    assign br_thread_id_o      = w_rdata[THREAD_WIDTH-1:0];
    assign branch_fifo_empty_o = w_empty;
    assign full_o              = w_full;
    assign count_o             = r_count;
    assign overflow_o          = r_overflow;

endmodule

// File: tb/tb_branch_fifo.sv
// Scoreboard bench for branch_fifo: stimulus queues expected heads, a negedge monitor checks pops.
module tb_branch_fifo;
    import branch_fifo_pkg::*;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    push_i;
    logic [XLEN-1:0]         push_pc_i;
    logic [THREAD_WIDTH-1:0] push_thread_id_i;
    logic                    br_ack_i;
    logic [XLEN-1:0]         br_pc_o;
    logic [THREAD_WIDTH-1:0] br_thread_id_o;
    logic                    branch_fifo_empty_o;
    logic                    full_o;
    logic [3:0]              count_o;
    logic                    overflow_o;

    branch_req_t exp_q[$];
    int checks = 0;
    int errors = 0;

    branch_fifo dut (
        .clk                 (clk),
        .rst                 (rst),
        .push_i              (push_i),
        .push_pc_i           (push_pc_i),
        .push_thread_id_i    (push_thread_id_i),
        .br_ack_i            (br_ack_i),
        .br_pc_o             (br_pc_o),
        .br_thread_id_o      (br_thread_id_o),
        .branch_fifo_empty_o (branch_fifo_empty_o),
        .full_o              (full_o),
        .count_o             (count_o),
        .overflow_o          (overflow_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Hold inputs for one rising edge, then release; returns at edge + 1.
    task automatic drive(input logic p, input logic [XLEN-1:0] pc,
                         input logic [THREAD_WIDTH-1:0] tid, input logic ack);
        push_i = p; push_pc_i = pc; push_thread_id_i = tid; br_ack_i = ack;
        @(posedge clk); #1;
        push_i = 1'b0; push_pc_i = '0; push_thread_id_i = '0; br_ack_i = 1'b0;
    endtask

    task automatic push_exp(input logic [XLEN-1:0] pc, input logic [THREAD_WIDTH-1:0] tid);
        branch_req_t e;
        e.pc = pc; e.thread_id = tid;
        exp_q.push_back(e);
    endtask

    // Monitor: every accepted pop must match the oldest expected redirect.
    always @(negedge clk) begin
        if (!rst && br_ack_i && !branch_fifo_empty_o) begin
            if (exp_q.size() == 0) begin
                chk("pop_unexpected", 64'(br_pc_o), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                branch_req_t e;
                e = exp_q.pop_front();
                chk("pop_pc", 64'(br_pc_o), 64'(e.pc));
                chk("pop_tid", 64'(br_thread_id_o), 64'(e.thread_id));
            end
        end
    end

    initial begin
        rst = 1'b1; push_i = 1'b0; push_pc_i = '0; push_thread_id_i = '0; br_ack_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_empty", 64'(branch_fifo_empty_o), 64'd1);
        chk("rst_full", 64'(full_o), 64'd0);
        chk("rst_count", 64'(count_o), 64'd0);
        chk("rst_ovf", 64'(overflow_o), 64'd0);
        chk("rst_pc", 64'(br_pc_o), 64'd0);
        chk("rst_tid", 64'(br_thread_id_o), 64'd0);
        rst = 1'b0;

        // single push, no bypass: empty drops only after the edge
        push_i = 1'b1; push_pc_i = 32'h8; push_thread_id_i = 3'd4;
        #2;
        chk("nobypass_empty", 64'(branch_fifo_empty_o), 64'd1);
        push_exp(32'h8, 3'd4);
        drive(1'b1, 32'h8, 3'd4, 1'b0);
        chk("push1_empty", 64'(branch_fifo_empty_o), 64'd0);
        chk("push1_pc", 64'(br_pc_o), 64'h8);
        chk("push1_tid", 64'(br_thread_id_o), 64'd4);
        drive(1'b0, '0, '0, 1'b1);
        chk("pop1_empty", 64'(branch_fifo_empty_o), 64'd1);
        chk("pop1_count", 64'(count_o), 64'd0);

        // fill to full, overflow attempt, drain
        for (int i = 0; i < 8; i++) begin
            push_exp(32'h100 + 32'(4 * i), 3'(i));
            drive(1'b1, 32'h100 + 32'(4 * i), 3'(i), 1'b0);
        end
        chk("fill_full", 64'(full_o), 64'd1);
        chk("fill_count", 64'(count_o), 64'd8);
        drive(1'b1, 32'h200, 3'd0, 1'b0);
`ifdef BRANCH_FIFO_DEDUP_EN
        exp_q[0].pc = 32'h200;
        chk("ovf_flag", 64'(overflow_o), 64'd0);
`else
        chk("ovf_flag", 64'(overflow_o), 64'd1);
`endif
        chk("ovf_count", 64'(count_o), 64'd8);
        for (int i = 0; i < 8; i++) drive(1'b0, '0, '0, 1'b1);
        chk("drain_empty", 64'(branch_fifo_empty_o), 64'd1);

        // push+pop at full
        for (int i = 0; i < 8; i++) begin
            push_exp(32'h100 + 32'(4 * i), 3'(i));
            drive(1'b1, 32'h100 + 32'(4 * i), 3'(i), 1'b0);
        end
        push_exp(32'h300, 3'd0);
        drive(1'b1, 32'h300, 3'd0, 1'b1);
        chk("pp_full_count", 64'(count_o), 64'd8);
        chk("pp_full_full", 64'(full_o), 64'd1);
`ifdef BRANCH_FIFO_DEDUP_EN
        chk("ovf_sticky", 64'(overflow_o), 64'd0);
`else
        chk("ovf_sticky", 64'(overflow_o), 64'd1);
`endif
        for (int i = 0; i < 8; i++) drive(1'b0, '0, '0, 1'b1);
        chk("drain2_empty", 64'(branch_fifo_empty_o), 64'd1);

        // push+pop at count=1: new entry becomes head
        push_exp(32'hA0, 3'd1);
        drive(1'b1, 32'hA0, 3'd1, 1'b0);
        push_exp(32'hB0, 3'd6);
        drive(1'b1, 32'hB0, 3'd6, 1'b1);
        chk("pp1_count", 64'(count_o), 64'd1);
        chk("pp1_head", 64'(br_pc_o), 64'hB0);
        drive(1'b0, '0, '0, 1'b1);

        // ack while empty, then reset mid-stream
        drive(1'b0, '0, '0, 1'b1);
        chk("ack_empty_count", 64'(count_o), 64'd0);
        chk("ack_empty_flag", 64'(branch_fifo_empty_o), 64'd1);
        drive(1'b1, 32'h10, 3'd1, 1'b0);
        drive(1'b1, 32'h14, 3'd2, 1'b0);
        drive(1'b1, 32'h18, 3'd3, 1'b0);
        chk("mid_count", 64'(count_o), 64'd3);
        rst = 1'b1;
        drive(1'b1, 32'h1C, 3'd5, 1'b1);
        rst = 1'b0;
        chk("mid_rst_empty", 64'(branch_fifo_empty_o), 64'd1);
        chk("mid_rst_count", 64'(count_o), 64'd0);
        chk("mid_rst_ovf", 64'(overflow_o), 64'd0);
        chk("mid_rst_pc", 64'(br_pc_o), 64'd0);

        // per-thread coalescing
        drive(1'b1, 32'h40, 3'd2, 1'b0);
        drive(1'b1, 32'h50, 3'd5, 1'b0);
        drive(1'b1, 32'h60, 3'd2, 1'b0);
`ifdef BRANCH_FIFO_DEDUP_EN
        push_exp(32'h60, 3'd2);
        push_exp(32'h50, 3'd5);
        chk("dedup_count", 64'(count_o), 64'd2);
        repeat (2) drive(1'b0, '0, '0, 1'b1);
`else
        push_exp(32'h40, 3'd2);
        push_exp(32'h50, 3'd5);
        push_exp(32'h60, 3'd2);
        chk("dedup_count", 64'(count_o), 64'd3);
        repeat (3) drive(1'b0, '0, '0, 1'b1);
`endif
        chk("final_empty", 64'(branch_fifo_empty_o), 64'd1);
        chk("scoreboard_left", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
